smplfifo_mc: RTL
================

Name: smplfifo_mc

Overview:
- Next-generation sample FIFO for the microphone capture path.
- Sits between the PMod MIC deserialiser and the wishbone register slave.
- Generalises the single-channel sample FIFO:
  - full-depth occupancy (FLEN entries usable, not FLEN-1);
  - selectable overflow policy (drop-newest or overwrite-oldest);
  - programmable fill-threshold interrupt;
  - sticky, clearable overflow and underflow flags.

Parameters:
- BW, 12: sample width in bits.
- LGFLEN, 9: log2 of depth; FLEN = 2^LGFLEN; legal range 2..14.
- OPT_OVERWRITE, 1'b0:
  - 0: write when full is dropped.
  - 1: write when full discards the oldest sample and stores the new one.

Ports:
- i_clk  in  1  sole clock.
- i_rst  in  1  synchronous, active-high reset.
- i_wr  in  1  write strobe; one sample per asserted cycle.
- i_data  in  BW  sample written when i_wr.
- i_rd  in  1  pop strobe; consumes o_data.
- o_empty_n  out  1  FIFO holds at least one sample; o_data valid.
- o_data  out  BW  oldest sample (first-word-fall-through).
- o_full  out  1  fill == FLEN.
- o_fill  out  LGFLEN+1  current occupancy, 0..FLEN.
- i_thresh  in  LGFLEN+1  interrupt threshold.
- o_int  out  1  level interrupt.
- i_clr_err  in  1  clears the sticky flags.
- o_ovfl  out  1  sticky overflow.
- o_unfl  out  1  sticky underflow.
- o_status  out  16  {fill[14:1] saturated/MSB-aligned as the legacy word, half-full, o_empty_n}; register-compatible with the existing driver.

Behaviour:
- Reset (i_rst high at a clock edge):
  - pointers := 0; fill := 0;
  - o_empty_n, o_full, o_int, o_ovfl, o_unfl := 0; o_data := 0.
  - Reset wins over all concurrent strobes.
  - Reset mid-stream discards all contents; memory contents are don't-care.
- Storage: FLEN x BW array with wr_ptr and rd_ptr, each LGFLEN bits, wrapping modulo FLEN.
- Fill tracking: fill is a separate LGFLEN+1 register, so full and empty are never ambiguous.
- Occupancy flags: o_fill, o_empty_n and o_full are registered and reflect the state after the edge's operations.
  - A write into an empty FIFO sets o_empty_n on the next edge.
  - o_data holds that sample in the same cycle o_empty_n rises (one-cycle write-to-read latency).
- o_data: registered head.
  - Pop with fill >= 2: o_data becomes mem[rd_ptr+1] on the next edge.
  - Pop leaving the FIFO empty while a write arrives: o_data takes i_data (bypass).
- Per-edge cases (F = fill before the edge):
  - wr only, F < FLEN: store at wr_ptr; wr_ptr++; fill++.
  - wr only, F == FLEN, OPT_OVERWRITE = 0: sample discarded; pointers and fill unchanged; o_ovfl := 1.
  - wr only, F == FLEN, OPT_OVERWRITE = 1: store at wr_ptr; wr_ptr++; rd_ptr++; fill stays FLEN; o_data advances to the next-oldest; o_ovfl := 1.
  - rd only, F > 0: rd_ptr++; fill--.
  - rd only, F == 0: ignored; o_unfl := 1.
  - wr and rd, 0 < F <= FLEN: both succeed; fill unchanged; no overflow even when full.
  - wr and rd, F == 0: write accepted; pop ignored; fill := 1; o_unfl := 1.
- o_int: registered, equals (i_thresh != 0) && (fill_next >= i_thresh). Threshold 0 disables the interrupt.
- i_clr_err: clears o_ovfl/o_unfl on the edge. A same-edge overflow or underflow takes priority, so the flag stays 1.
- Half-full bit: fill >= FLEN/2.

Optional Feature:
- Macro: SMPLFIFO_MC_HIWATER_EN.
- Enabled:
  - adds output o_hiwater, LGFLEN+1 bits, reset 0;
  - registers the maximum fill reached since reset or the last i_clr_err;
  - on an i_clr_err edge, loads the current fill_next.
- Disabled: port absent; no logic.

Decomposition:
- Package smplfifo_pkg holds:
  - localparam helpers for FLEN and fill width;
  - the status-word bit positions (STAT_EMPTY_N = 0, STAT_HALF = 1, STAT_FILL_LSB = 2);
  - the overflow-policy constants OVF_DROP / OVF_OVERWRITE.
- One natural sub-module, smplfifo_ram: simple dual-port, one write port, registered read.
- Pointer, fill and flag control stays in smplfifo_mc.

Test Plan:
- Fill sequence (LGFLEN=4): write 16 samples 0x001..0x010 -> o_fill = 16, o_full = 1, o_ovfl = 0. Then pop 16 -> o_data reads 0x001..0x010 in order; o_empty_n = 0 after the last pop.
- Drop mode: full FIFO with 0x001..0x010, write 0xABC -> o_ovfl = 1, o_fill = 16. Drain returns 0x001..0x010; 0xABC is absent.
- Overwrite mode: same stimulus with OPT_OVERWRITE = 1 -> o_ovfl = 1, o_data = 0x002. Drain returns 0x002..0x010 then 0xABC.
- Empty edge cases:
  - pop on empty -> o_unfl = 1, o_fill = 0;
  - simultaneous wr 0x055 + rd on empty -> o_fill = 1, o_data = 0x055;
  - i_clr_err -> both flags 0.
- Threshold: i_thresh = 5; writes 1..5 -> o_int rises on the edge after the 5th write; one pop -> o_int falls; i_thresh = 0 -> o_int stays 0.
- Reset during simultaneous wr/rd at fill 9 -> next cycle o_fill = 0, o_empty_n = 0, flags 0; the following write/pop round-trips correctly.

Source files
------------

// File: rtl/smplfifo_pkg.sv
// Shared definitions for the multi-channel-generation sample FIFO:
// depth helpers, status-word layout, overflow-policy encodings and the
// sticky-flag update rule.
package smplfifo_pkg;

   // Status word layout (register-compatible with the legacy driver)
   localparam int STAT_W        = 16;
   localparam int STAT_EMPTY_N  = 0;
   localparam int STAT_HALF     = 1;
   localparam int STAT_FILL_LSB = 2;
   localparam int STAT_FILL_W   = 14;

   // Overflow policy selector values
   localparam logic OVF_DROP      = 1'b0;
   localparam logic OVF_OVERWRITE = 1'b1;

   // Number of entries for a given log2 depth
   function automatic int flen(input int lgflen);
      return 32'sd1 << lgflen;
   endfunction

   // Width of an occupancy count able to hold 0..FLEN
   function automatic int fill_w(input int lgflen);
      return lgflen + 32'sd1;
   endfunction

   // Sticky flag: a new event wins over a clear, a clear wins over hold
   function automatic logic sticky_next(input logic cur, input logic ev, input logic clr);
      logic nxt;
      if (ev) begin
         nxt = 1'b1;
      end else if (clr) begin
         nxt = 1'b0;
      end else begin
         nxt = cur;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/smplfifo_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// A read of the address being written on the same edge returns the new
// data, so a freshly written head sample appears one cycle after its write.
module smplfifo_ram #(
   parameter int BW = 12,
   parameter int AW = 9
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [BW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [BW-1:0] o_rdata
);

   logic [BW-1:0] r_mem [0:(1<<AW)-1];

   // Write port; array contents are never reset
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Registered read with write-first forwarding, output cleared on reset
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_rdata <= '0;
      end else if (i_we && (i_waddr == i_raddr)) begin
         o_rdata <= i_wdata;
      end else begin
         o_rdata <= r_mem[i_raddr];
      end
   end

endmodule

// File: rtl/smplfifo_mc.sv
// Sample FIFO for the microphone capture path. Full-depth occupancy via a
// separate fill counter, drop-newest or overwrite-oldest overflow policy,
// fill-threshold level interrupt, sticky clearable overflow/underflow flags
// and a legacy-compatible status word.
// Optional build macro SMPLFIFO_MC_HIWATER_EN adds o_hiwater, the highest
// fill seen since reset or the last i_clr_err.
// LGFLEN legal range is 2..14.
module smplfifo_mc
   import smplfifo_pkg::*;
#(
   parameter int   BW            = 12,
   parameter int   LGFLEN        = 9,
   parameter logic OPT_OVERWRITE = OVF_DROP
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr,
   input  logic [BW-1:0]     i_data,
   input  logic              i_rd,
   output logic              o_empty_n,
   output logic [BW-1:0]     o_data,
   output logic              o_full,
   output logic [LGFLEN:0]   o_fill,
   input  logic [LGFLEN:0]   i_thresh,
   output logic              o_int,
   input  logic              i_clr_err,
   output logic              o_ovfl,
   output logic              o_unfl,
   output logic [15:0]       o_status
`ifdef SMPLFIFO_MC_HIWATER_EN
   ,
   output logic [LGFLEN:0]   o_hiwater
`endif
);

   localparam int             FW        = fill_w(LGFLEN);
   localparam logic [FW-1:0]  FILL_MAX  = FW'(flen(LGFLEN));
   localparam logic [FW-1:0]  FILL_HALF = FW'(flen(LGFLEN) / 2);
   localparam int             ALIGN     = STAT_FILL_W - LGFLEN;

   logic [LGFLEN-1:0] r_wr_ptr;
   logic [LGFLEN-1:0] r_rd_ptr;
   logic [FW-1:0]     r_fill;

   logic              w_wr_acc;
   logic              w_rd_adv;
   logic              w_ovf_ev;
   logic              w_unf_ev;
   logic [LGFLEN-1:0] w_wr_ptr_next;
   logic [LGFLEN-1:0] w_rd_ptr_next;
   logic [FW-1:0]     w_fill_next;
   logic [LGFLEN-1:0] w_sat_lo;
   logic [STAT_FILL_W-1:0] w_stat_fill;
   logic [STAT_W-1:0] w_status_next;

   // Classify this edge's strobes into accepted write, head advance and error events
   always_comb begin
      w_wr_acc = 1'b0;
      w_rd_adv = 1'b0;
      w_ovf_ev = 1'b0;
      w_unf_ev = 1'b0;
      case ({i_wr, i_rd})
         2'b11: begin
            // Simultaneous push/pop never overflows; on empty only the push lands
            w_wr_acc = 1'b1;
            if (r_fill == '0) begin
               w_unf_ev = 1'b1;
            end else begin
               w_rd_adv = 1'b1;
            end
         end
         2'b10: begin
            if (r_fill != FILL_MAX) begin
               w_wr_acc = 1'b1;
            end else if (OPT_OVERWRITE == OVF_OVERWRITE) begin
               // Evict the oldest sample to make room
               w_wr_acc = 1'b1;
               w_rd_adv = 1'b1;
               w_ovf_ev = 1'b1;
            end else begin
               w_ovf_ev = 1'b1;
            end
         end
         2'b01: begin
            if (r_fill != '0) begin
               w_rd_adv = 1'b1;
            end else begin
               w_unf_ev = 1'b1;
            end
         end
         default: begin
            w_wr_acc = 1'b0;
         end
      endcase
   end

   // Next pointers, occupancy and status word after this edge
   always_comb begin
      w_wr_ptr_next = w_wr_acc ? (r_wr_ptr + LGFLEN'(1'b1)) : r_wr_ptr;
      w_rd_ptr_next = w_rd_adv ? (r_rd_ptr + LGFLEN'(1'b1)) : r_rd_ptr;
      case ({w_wr_acc, w_rd_adv})
         2'b10:   w_fill_next = r_fill + FW'(1'b1);
         2'b01:   w_fill_next = r_fill - FW'(1'b1);
         default: w_fill_next = r_fill;
      endcase
      // Legacy field holds at most FLEN-1, left-aligned in a 14-bit slot
      if (w_fill_next == FILL_MAX) begin
         w_sat_lo = {LGFLEN{1'b1}};
      end else begin
         w_sat_lo = w_fill_next[LGFLEN-1:0];
      end
      w_stat_fill = STAT_FILL_W'(w_sat_lo) << ALIGN;
      w_status_next = {STAT_W{1'b0}};
      w_status_next[STAT_FILL_LSB +: STAT_FILL_W] = w_stat_fill;
      w_status_next[STAT_HALF]    = (w_fill_next >= FILL_HALF);
      w_status_next[STAT_EMPTY_N] = (w_fill_next != '0);
   end

   // Pointer, occupancy, flag and interrupt registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_fill    <= '0;
         o_empty_n <= 1'b0;
         o_full    <= 1'b0;
         o_int     <= 1'b0;
         o_ovfl    <= 1'b0;
         o_unfl    <= 1'b0;
         o_status  <= '0;
      end else begin
         r_wr_ptr  <= w_wr_ptr_next;
         r_rd_ptr  <= w_rd_ptr_next;
         r_fill    <= w_fill_next;
         o_empty_n <= (w_fill_next != '0);
         o_full    <= (w_fill_next == FILL_MAX);
         o_int     <= (i_thresh != '0) && (w_fill_next >= i_thresh);
         o_ovfl    <= sticky_next(o_ovfl, w_ovf_ev, i_clr_err);
         o_unfl    <= sticky_next(o_unfl, w_unf_ev, i_clr_err);
         o_status  <= w_status_next;
      end
   end

   assign o_fill = r_fill;

   // The RAM reads the post-edge head address so o_data is the registered head
   smplfifo_ram #(
      .BW (BW),
      .AW (LGFLEN)
   ) u_ram (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_we    (w_wr_acc && !i_rst),
      .i_waddr (r_wr_ptr),
      .i_wdata (i_data),
      .i_raddr (w_rd_ptr_next),
      .o_rdata (o_data)
   );

`ifdef SMPLFIFO_MC_HIWATER_EN
   // High-water mark: restarts from the current fill on a clear
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_hiwater <= '0;
      end else if (i_clr_err) begin
         o_hiwater <= w_fill_next;
      end else if (w_fill_next > o_hiwater) begin
         o_hiwater <= w_fill_next;
      end else begin
         o_hiwater <= o_hiwater;
      end
   end
`endif

endmodule
